alu_cmd_queue: RTL and testbench

- Command buffer directly upstream of the ALU.
- Accepts ALU commands (opcode, A, B, cin, reduction selects) from the stimulus/control side over a valid/ready handshake and screens out illegal combinations.
- Buffers legal commands in a small FIFO and presents them in order to the ALU input stage over a second valid/ready handshake.
- Counts issued commands and rejected commands for scoreboard correlation.

---
 rtl/alu_cmd_queue.sv | 151 +++++++++++++++
 tb/tb_alu_cmd_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// ALU command queue: screens illegal commands, buffers legal ones in order, counts issues/rejects.
// Latency: 1 cycle from accept to head when empty; no in->out bypass.
// Backpressure: in_ready drops when full (registered state only); the head holds while out_ready is low.

// Generic show-ahead FIFO; contents are not reset, only pointers and count.
// Latency: a write is visible at the head on the next cycle.
// Backpressure: ignores push when full and pop when empty.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              push_dat,
    input  logic                       pop,
    output logic [DW-1:0]              head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && (count != FULL_CNT);
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module alu_cmd_queue #(
    parameter int WIDTH_AB  = 3,
    parameter int DEPTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_opcode,
    input  logic [WIDTH_AB-1:0]       in_A,
    input  logic [WIDTH_AB-1:0]       in_B,
    input  logic                      in_cin,
    input  logic                      in_red_op_A,
    input  logic                      in_red_op_B,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_opcode,
    output logic [WIDTH_AB-1:0]       out_A,
    output logic [WIDTH_AB-1:0]       out_B,
    output logic                      out_cin,
    output logic                      out_red_op_A,
    output logic                      out_red_op_B,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      err_pulse,
    output logic [ERR_CNT_W-1:0]      err_cnt,
    output logic [15:0]               issued_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [2:0]          opcode;
        logic [WIDTH_AB-1:0] a;
        logic [WIDTH_AB-1:0] b;
        logic                cin;
        logic                red_op_a;
        logic                red_op_b;
    } cmd_t;

    cmd_t in_cmd;
    cmd_t head_cmd;
    cmd_t out_cmd;
    logic accept;
    logic illegal;
    logic push;
    logic pop;

    assign in_cmd = '{opcode: in_opcode, a: in_A, b: in_B, cin: in_cin,
                      red_op_a: in_red_op_A, red_op_b: in_red_op_B};

    // Reductions are only meaningful for OR (0) and XOR (1); opcodes 6/7 are unassigned.
    assign illegal = (in_opcode[2:1] == 2'b11) ||
                     ((in_red_op_A || in_red_op_B) && (in_opcode[2:1] != 2'b00));

    assign in_ready  = !rst && (count != FULL_CNT);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !illegal;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .DW    ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (in_cmd),
        .pop      (pop),
        .head_dat (head_cmd),
        .count    (count)
    );

    assign out_cmd      = out_valid ? head_cmd : '0;
    assign out_opcode   = out_cmd.opcode;
    assign out_A        = out_cmd.a;
    assign out_B        = out_cmd.b;
    assign out_cin      = out_cmd.cin;
    assign out_red_op_A = out_cmd.red_op_a;
    assign out_red_op_B = out_cmd.red_op_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
            issued_cnt <= '0;
        end else begin
            err_pulse <= accept && illegal;
            if (accept && illegal && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
            if (pop) begin
                issued_cnt <= issued_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed vector bench for alu_cmd_queue: fill, drain, concurrent wrap, reject, reset, saturation.
module tb_alu_cmd_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [2:0] in_A;
    logic [2:0] in_B;
    logic       in_cin;
    logic       in_red_op_A;
    logic       in_red_op_B;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_opcode;
    logic [2:0] out_A;
    logic [2:0] out_B;
    logic       out_cin;
    logic       out_red_op_A;
    logic       out_red_op_B;
    logic [2:0] count;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [15:0] issued_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_cmd_queue #(.WIDTH_AB(3), .DEPTH(4), .ERR_CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_A         (in_A),
        .in_B         (in_B),
        .in_cin       (in_cin),
        .in_red_op_A  (in_red_op_A),
        .in_red_op_B  (in_red_op_B),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_A        (out_A),
        .out_B        (out_B),
        .out_cin      (out_cin),
        .out_red_op_A (out_red_op_A),
        .out_red_op_B (out_red_op_B),
        .count        (count),
        .err_pulse    (err_pulse),
        .err_cnt      (err_cnt),
        .issued_cnt   (issued_cnt)
    );

    typedef struct {
        int v, op, a, b, cin, ra, rb, ordy;
        int e_rdy, e_cnt, e_ov, e_op, e_a, e_b, e_cin, e_ra, e_rb, e_ep, e_ec, e_ic;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int v, input int op, input int a, input int b,
                         input int cin, input int ra, input int rb, input int ordy);
        in_valid    = v[0];
        in_opcode   = op[2:0];
        in_A        = a[2:0];
        in_B        = b[2:0];
        in_cin      = cin[0];
        in_red_op_A = ra[0];
        in_red_op_B = rb[0];
        out_ready   = ordy[0];
    endtask

    task automatic check_head(input string tag, input int op, input int a, input int b,
                              input int cin, input int ra, input int rb);
        check({tag, ".out_opcode"},   int'(out_opcode),   op);
        check({tag, ".out_A"},        int'(out_A),        a);
        check({tag, ".out_B"},        int'(out_B),        b);
        check({tag, ".out_cin"},      int'(out_cin),      cin);
        check({tag, ".out_red_op_A"}, int'(out_red_op_A), ra);
        check({tag, ".out_red_op_B"}, int'(out_red_op_B), rb);
    endtask

    initial begin
        //           v op a b c ra rb or | rdy cnt ov op a b c ra rb ep ec ic
        vecs[0]  = '{1,0,5,2,0,0,0,0, 1,1,1,0,5,2,0,0,0,0,0,0};
        vecs[1]  = '{1,1,5,2,0,0,0,0, 1,2,1,0,5,2,0,0,0,0,0,0};
        vecs[2]  = '{1,2,5,2,0,0,0,0, 1,3,1,0,5,2,0,0,0,0,0,0};
        vecs[3]  = '{1,3,5,2,0,0,0,0, 0,4,1,0,5,2,0,0,0,0,0,0};
        vecs[4]  = '{1,4,5,2,0,0,0,0, 0,4,1,0,5,2,0,0,0,0,0,0};
        vecs[5]  = '{0,0,0,0,0,0,0,1, 1,3,1,1,5,2,0,0,0,0,0,1};
        vecs[6]  = '{0,0,0,0,0,0,0,1, 1,2,1,2,5,2,0,0,0,0,0,2};
        vecs[7]  = '{0,0,0,0,0,0,0,1, 1,1,1,3,5,2,0,0,0,0,0,3};
        vecs[8]  = '{0,0,0,0,0,0,0,1, 1,0,0,0,0,0,0,0,0,0,0,4};
        vecs[9]  = '{1,2,1,2,0,0,0,0, 1,1,1,2,1,2,0,0,0,0,0,4};
        vecs[10] = '{1,2,2,2,0,0,0,0, 1,2,1,2,1,2,0,0,0,0,0,4};
        vecs[11] = '{1,2,3,2,0,0,0,1, 1,2,1,2,2,2,0,0,0,0,0,5};
        vecs[12] = '{1,2,4,2,0,0,0,1, 1,2,1,2,3,2,0,0,0,0,0,6};
        vecs[13] = '{1,2,5,2,0,0,0,1, 1,2,1,2,4,2,0,0,0,0,0,7};
        vecs[14] = '{1,2,6,2,0,0,0,1, 1,2,1,2,5,2,0,0,0,0,0,8};
        vecs[15] = '{1,2,7,2,0,0,0,1, 1,2,1,2,6,2,0,0,0,0,0,9};
        vecs[16] = '{1,6,0,0,0,0,0,0, 1,2,1,2,6,2,0,0,0,1,1,9};
        vecs[17] = '{0,0,0,0,0,0,0,0, 1,2,1,2,6,2,0,0,0,0,1,9};
        vecs[18] = '{1,2,0,0,0,1,0,0, 1,2,1,2,6,2,0,0,0,1,2,9};
        vecs[19] = '{0,0,0,0,0,0,0,0, 1,2,1,2,6,2,0,0,0,0,2,9};
        vecs[20] = '{1,1,0,0,0,0,1,0, 1,3,1,2,6,2,0,0,0,0,2,9};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready",   int'(in_ready),   0);
        check("rst.count",      int'(count),      0);
        check("rst.out_valid",  int'(out_valid),  0);
        check("rst.err_pulse",  int'(err_pulse),  0);
        check("rst.err_cnt",    int'(err_cnt),    0);
        check("rst.issued_cnt", int'(issued_cnt), 0);
        check_head("rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel.in_ready", int'(in_ready), 1);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].cin, vecs[i].ra, vecs[i].rb, vecs[i].ordy);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.in_ready", i),   int'(in_ready),   vecs[i].e_rdy);
            check($sformatf("v%0d.count", i),      int'(count),      vecs[i].e_cnt);
            check($sformatf("v%0d.out_valid", i),  int'(out_valid),  vecs[i].e_ov);
            check($sformatf("v%0d.err_pulse", i),  int'(err_pulse),  vecs[i].e_ep);
            check($sformatf("v%0d.err_cnt", i),    int'(err_cnt),    vecs[i].e_ec);
            check($sformatf("v%0d.issued_cnt", i), int'(issued_cnt), vecs[i].e_ic);
            check_head($sformatf("v%0d", i), vecs[i].e_op, vecs[i].e_a, vecs[i].e_b,
                       vecs[i].e_cin, vecs[i].e_ra, vecs[i].e_rb);
        end

        // Mid-stream reset with three entries queued.
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("mrst.count",      int'(count),      0);
        check("mrst.out_valid",  int'(out_valid),  0);
        check("mrst.err_cnt",    int'(err_cnt),    0);
        check("mrst.issued_cnt", int'(issued_cnt), 0);
        check("mrst.in_ready",   int'(in_ready),   0);
        check_head("mrst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 3, 4, 1, 1, 0, 0);
        #1;
        check("mrst_push.pre_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("mrst_push.count",     int'(count),     1);
        check("mrst_push.out_valid", int'(out_valid), 1);
        check_head("mrst_push", 0, 3, 4, 1, 1, 0);

        // Reject counter saturation.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(1, 7, i % 8, 1, 0, 0, 0, 0);
            @(posedge clk);
            #1;
            check($sformatf("sat%0d.err_pulse", i), int'(err_pulse), 1);
            check($sformatf("sat%0d.err_cnt", i),   int'(err_cnt),   (i + 1 > 255) ? 255 : i + 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("sat_end.err_pulse", int'(err_pulse), 0);
        check("sat_end.err_cnt",   int'(err_cnt),   255);
        check("sat_end.count",     int'(count),     1);
        check_head("sat_end", 0, 3, 4, 1, 1, 0);

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        check("final.issued_cnt", int'(issued_cnt), 1);
        check("final.count",      int'(count),      0);
        check("final.out_valid",  int'(out_valid),  0);
        check_head("final", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
